fifo_drain_streamer: RTL and testbench

Read-side companion to the design's 64-bit word FIFO. On a start pulse it pops a programmed number of words from the FIFO's `rd`/`empty`/`dout` port and presents them on a valid/ready stream toward the host/PCIe readout logic. The FIFO's one-cycle read latency is absorbed with a credit-controlled 4-entry skid buffer, so throughput is one word per cycle under no backpressure and no word is lost under backpressure.

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/fifo_drain_skid.sv | 58 +++++
 rtl/fifo_drain_streamer.sv | 138 +++++++++++++
 tb/tb_fifo_drain_streamer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing for the FIFO drain streamer and its skid buffer.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 4;
  localparam int SKID_ABITS = 2;

endpackage

// File: rtl/fifo_drain_skid.sv
// Four-entry in-order stream buffer that absorbs the FIFO read latency.
// Each entry carries its data word and a last-word tag.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DBITS = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DBITS-1:0]      push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [SKID_ABITS:0]   occ,
  output logic                  head_valid,
  output logic [DBITS-1:0]      head_data,
  output logic                  head_last
);

  logic [DBITS-1:0]      mem      [SKID_DEPTH];
  logic                  last_mem [SKID_DEPTH];
  logic [SKID_ABITS-1:0] wr_ptr;
  logic [SKID_ABITS-1:0] rd_ptr;
  logic                  pop_ok;

  assign head_valid = (occ != '0);
  assign pop_ok     = pop & head_valid;
  assign head_data  = mem[rd_ptr];
  assign head_last  = last_mem[rd_ptr] & head_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i]      <= '0;
        last_mem[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      // Credit control upstream guarantees a push never lands on a full buffer.
      if (push) begin
        mem[wr_ptr]      <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_streamer.sv
// Drains a programmed number of words from a 1-cycle-latency FIFO onto a valid/ready stream.
// Optional empty-stall abort is enabled by defining FIFO_DRAIN_TIMEOUT_EN.
module fifo_drain_streamer
  import fifo_drain_pkg::*;
#(
  parameter int DBITS       = 64,
  parameter int LEN_BITS    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_BITS-1:0] burst_len,
  output logic                busy,
  output logic                done,
  output logic [LEN_BITS-1:0] words_sent,
  output logic                timeout,
  output logic                fifo_rd,
  input  logic                fifo_empty,
  input  logic [DBITS-1:0]    fifo_dout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DBITS-1:0]    m_data,
  output logic                m_last,
  output state_t              fsm_state
);

  // Stream handshake: a word transfers on every cycle with m_valid & m_ready;
  // while m_valid is high and m_ready low, m_data and m_last do not change.

  state_t                state;
  logic [LEN_BITS-1:0]   len;
  logic [LEN_BITS-1:0]   issued;
  logic                  inflight;
  logic                  inflight_last;
  logic [SKID_ABITS:0]   occ;
  logic [SKID_ABITS+1:0] fill;
  logic                  credit_ok;
  logic                  hs;
  logic                  drain_empty;
  logic                  stall_hit;

  assign fsm_state   = state;
  assign fill        = {1'b0, occ} + {{(SKID_ABITS+1){1'b0}}, inflight};
  assign credit_ok   = (fill < (SKID_ABITS+2)'(SKID_DEPTH));
  assign fifo_rd     = (state == RUN) & ~fifo_empty & (issued < len) & credit_ok;
  assign hs          = m_valid & m_ready;
  // Buffer plus in-flight slot reach zero on this edge (covers the final pop).
  assign drain_empty = (fill == {{(SKID_ABITS+1){1'b0}}, hs});

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int SBITS = $clog2(TIMEOUT_CYC + 1);
  logic [SBITS-1:0] stall_cnt;
  logic             stall_inc;

  assign stall_inc = (state == RUN) & fifo_empty & (issued < len);
  assign stall_hit = stall_inc & (stall_cnt == SBITS'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state != RUN) || fifo_rd) begin
      stall_cnt <= '0;
    end else if (stall_inc) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign stall_hit          = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      issued        <= '0;
      words_sent    <= '0;
      timeout       <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      // Tag at issue time; an aborted burst never issues its final word.
      inflight_last <= fifo_rd & (issued == len - 1'b1);
      if (fifo_rd) issued <= issued + 1'b1;
      if (hs) words_sent <= words_sent + 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len        <= burst_len;
            issued     <= '0;
            words_sent <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (stall_hit) begin
            timeout <= 1'b1;
            state   <= FLUSH;
          end else if (issued == len) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (drain_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  fifo_drain_skid #(.DBITS(DBITS)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight),
    .push_data  (fifo_dout),
    .push_last  (inflight_last),
    .pop        (hs),
    .occ        (occ),
    .head_valid (m_valid),
    .head_data  (m_data),
    .head_last  (m_last)
  );

endmodule

// File: tb/tb_fifo_drain_streamer.sv
// Directed bench for fifo_drain_streamer with a registered-empty FIFO model and stream scoreboard.
module tb_fifo_drain_streamer;
  import fifo_drain_pkg::*;

  localparam int DBITS       = 64;
  localparam int LEN_BITS    = 16;
  localparam int TIMEOUT_CYC = 16;
`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int REFILL_AT   = 10;
`else
  localparam int REFILL_AT   = 20;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [LEN_BITS-1:0] burst_len = '0;
  logic                busy, done, timeout, fifo_rd, m_valid, m_last;
  logic [LEN_BITS-1:0] words_sent;
  logic                fifo_empty = 1'b1;
  logic [DBITS-1:0]    fifo_dout = '0;
  logic                m_ready = 1'b0;
  logic [DBITS-1:0]    m_data;
  state_t              fsm_state;

  int checks = 0;
  int errors = 0;
  int rd_on_empty = 0;
  int done_cnt = 0;

  logic [DBITS-1:0] fifo_q[$];
  logic [DBITS-1:0] got_q[$];
  logic             got_last_q[$];
  logic [DBITS-1:0] exp_q[$];
  logic             exp_last_q[$];

  fifo_drain_streamer #(
    .DBITS(DBITS), .LEN_BITS(LEN_BITS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .words_sent(words_sent), .timeout(timeout),
    .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fsm_state(fsm_state)
  );

  // Clock
  always #5 clock = ~clock;

  // FIFO model: one-cycle read latency, registered empty flag
  always @(posedge clock) begin
    if (fifo_rd) begin
      if (fifo_empty || fifo_q.size() == 0) rd_on_empty++;
      else fifo_dout <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Stream monitor
  always @(posedge clock) begin
    if (!reset && m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_last_q.push_back(m_last);
    end
    if (!reset && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic expect_words(input logic [DBITS-1:0] first, input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(first + DBITS'(i));
      exp_last_q.push_back(last_on_final && (i == n - 1));
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      chk({tag, "_last"}, got_last_q.pop_front(), exp_last_q.pop_front());
    end
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
    exp_last_q.delete();
  endtask

  task automatic preload(input logic [DBITS-1:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + DBITS'(i));
    tick();
    tick();
  endtask

  initial begin
    int rd_cnt;
    int valid_cnt;
    int done_c;
    int done_base;

    // Reset state
    tick();
    tick();
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_words_sent", words_sent, 16'h0);
    chk("rst_state", fsm_state, IDLE);
    reset = 1'b0;
    tick();

    // T1: 8 words, no backpressure, cycle-exact timing
    preload(64'h01, 8);
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 16'd8;
    for (int c = 0; c <= 12; c++) begin
      chk("t1_rd", fifo_rd, (c >= 1 && c <= 8));
      chk("t1_valid", m_valid, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("t1_data", m_data, 64'(c - 2));
      chk("t1_last", m_last, (c == 10));
      chk("t1_done", done, (c == 11));
      chk("t1_busy", busy, (c >= 1 && c <= 10));
      tick();
      start = 1'b0;
    end
    chk("t1_words_sent", words_sent, 16'd8);
    got_q.delete();
    got_last_q.delete();

    // T2: sink stalled cycles 0..15, then released
    preload(64'h01, 8);
    m_ready   = 1'b0;
    start     = 1'b1;
    burst_len = 16'd8;
    rd_cnt    = 0;
    for (int c = 0; c <= 15; c++) begin
      rd_cnt += int'(fifo_rd);
      if (c >= 3) begin
        chk("t2_valid_held", m_valid, 1'b1);
        chk("t2_data_held", m_data, 64'h01);
        chk("t2_last_held", m_last, 1'b0);
      end
      tick();
      start = 1'b0;
    end
    chk("t2_rd_count", rd_cnt, 4);
    m_ready = 1'b1;
    wait_done("t2", 60);
    expect_words(64'h01, 8, 1'b1);
    check_stream("t2");
    chk("t2_words_sent", words_sent, 16'd8);
    tick();

    // T3: zero-length burst
    start     = 1'b1;
    burst_len = 16'd0;
    rd_cnt    = 0;
    valid_cnt = 0;
    done_c    = -1;
    for (int c = 0; c <= 6; c++) begin
      rd_cnt    += int'(fifo_rd);
      valid_cnt += int'(m_valid);
      if (done && done_c < 0) done_c = c;
      tick();
      start = 1'b0;
    end
    chk("t3_rd_count", rd_cnt, 0);
    chk("t3_valid_count", valid_cnt, 0);
    chk("t3_done_by_3", (done_c >= 1 && done_c <= 3), 1'b1);
    chk("t3_words_sent", words_sent, 16'd0);

    // T4: FIFO runs dry mid-burst, refilled later
    preload(64'h11, 2);
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 16'd4;
    for (int c = 0; c < REFILL_AT; c++) begin
      tick();
      start = 1'b0;
    end
    chk("t4_busy_waiting", busy, 1'b1);
    chk("t4_no_valid_waiting", m_valid, 1'b0);
    fifo_q.push_back(64'h13);
    fifo_q.push_back(64'h14);
    wait_done("t4", 60);
    expect_words(64'h11, 4, 1'b1);
    check_stream("t4");
    chk("t4_words_sent", words_sent, 16'd4);
    chk("t4_timeout", timeout, 1'b0);
    tick();

`ifdef FIFO_DRAIN_TIMEOUT_EN
    // T5: short FIFO aborts on empty stall
    preload(64'h31, 3);
    done_base = done_cnt;
    start     = 1'b1;
    burst_len = 16'd5;
    tick();
    start = 1'b0;
    wait_done("t5", 80);
    tick();
    expect_words(64'h31, 3, 1'b0);
    check_stream("t5");
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_words_sent", words_sent, 16'd3);
    chk("t5_done_pulses", done_cnt - done_base, 1);
`else
    done_base = done_cnt;
    chk("t5_timeout_tied", timeout, 1'b0);
    chk("t5_no_stray_done", done_cnt - done_base, 0);
`endif

    // T6: reset mid-burst, then a clean burst
    preload(64'h01, 8);
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 16'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && words_sent != 16'd2; i++) tick();
    chk("t6_reached_ws2", words_sent, 16'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_fifo_rd", fifo_rd, 1'b0);
    chk("t6_rst_m_valid", m_valid, 1'b0);
    chk("t6_rst_m_data", m_data, 64'h0);
    chk("t6_rst_m_last", m_last, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_words_sent", words_sent, 16'h0);
    chk("t6_rst_timeout", timeout, 1'b0);
    chk("t6_rst_state", fsm_state, IDLE);
    tick();
    fifo_q.delete();
    tick();
    reset = 1'b0;
    tick();
    got_q.delete();
    got_last_q.delete();
    preload(64'h21, 4);
    start     = 1'b1;
    burst_len = 16'd4;
    tick();
    start = 1'b0;
    wait_done("t6", 40);
    expect_words(64'h21, 4, 1'b1);
    check_stream("t6");
    chk("t6_words_sent", words_sent, 16'd4);

    chk("rd_never_on_empty", rd_on_empty, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
